traffic_generator_gmii_scheduler: RTL and testbench

//  Sequences frame transmission for the GMII traffic generator using the CPU-written config:
//  IFG, inter-burst gap, frames per burst, total frames and frame size.

---
 rtl/traffic_generator_gmii_scheduler_if.sv | 29 ++
 rtl/traffic_generator_gmii_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_traffic_generator_gmii_scheduler.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_generator_gmii_scheduler_if.sv
// ---------------------------------------------------------------------------
// traffic_generator_gmii_scheduler_if
// Start/complete handshake between the frame scheduler and the frame emitter.
//   tx_start  scheduler -> emitter  one-cycle start request
//   tx_len    scheduler -> emitter  clamped frame length in bytes
//   tx_ready  emitter -> scheduler  emitter idle, can accept a start
//   tx_done   emitter -> scheduler  one-cycle pulse, current frame finished
// master = scheduler side, slave = emitter side.
// ---------------------------------------------------------------------------
interface traffic_generator_gmii_scheduler_if;
  logic        tx_start;
  logic [15:0] tx_len;
  logic        tx_ready;
  logic        tx_done;

  modport master (
    output tx_start,
    output tx_len,
    input  tx_ready,
    input  tx_done
  );

  modport slave (
    input  tx_start,
    input  tx_len,
    output tx_ready,
    output tx_done
  );
endinterface

// File: rtl/traffic_generator_gmii_scheduler.sv
// ---------------------------------------------------------------------------
// traffic_generator_gmii_scheduler
// Sequences frame transmission for the GMII traffic generator. A rising edge
// of enable latches the configuration and starts a run; one start is issued
// per frame, with the inter-frame / inter-burst gaps inserted between frames,
// until total_frames have completed (or forever when total_frames is 0).
//
// Ports
//   clk               single clock
//   resetn            synchronous active-low reset
//   enable            run enable; a 0->1 edge starts a run
//   interframe_gap    idle cycles between frames inside a burst
//   interburst_gap    idle cycles after the last frame of a burst
//   frames_per_burst  frames per burst, 0 = no bursts
//   total_frames      frames per run, 0 = endless
//   frame_size        requested frame length in bytes
//   tx                handshake to the frame emitter (master modport)
//   pkts              frames completed in the current or last run
//   busy              run in progress
//   done              total_frames reached, held until enable drops
// ---------------------------------------------------------------------------
module traffic_generator_gmii_scheduler #(
  parameter int C_FRAME_BUF_ADDRESS_WIDTH = 9,
  parameter int C_MIN_FRAME_SIZE          = 60
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic                                   enable,
  input  logic [31:0]                            interframe_gap,
  input  logic [31:0]                            interburst_gap,
  input  logic [31:0]                            frames_per_burst,
  input  logic [63:0]                            total_frames,
  input  logic [15:0]                            frame_size,
  traffic_generator_gmii_scheduler_if.master     tx,
  output logic [63:0]                            pkts,
  output logic                                   busy,
  output logic                                   done
);

  // Frame length bounds in bytes; the buffer holds 2^AW 32-bit words.
  localparam logic [31:0] MIN_FRAME_LEN = 32'(C_MIN_FRAME_SIZE);
  localparam logic [31:0] MAX_FRAME_LEN = 32'd4 << C_FRAME_BUF_ADDRESS_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_GAP       = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

  // Clamp the requested length into [MIN_FRAME_LEN, MAX_FRAME_LEN].
  function automatic logic [15:0] clamp_len(input logic [15:0] size);
    logic [31:0] size_w;
    logic [15:0] res;
    size_w = {16'd0, size};
    if (size_w < MIN_FRAME_LEN) begin
      res = MIN_FRAME_LEN[15:0];
    end else if (size_w > MAX_FRAME_LEN) begin
      res = MAX_FRAME_LEN[15:0];
    end else begin
      res = size;
    end
    return res;
  endfunction

  state_t      state_r;
  logic        enable_d_r;
  logic [31:0] ifg_r;
  logic [31:0] ibg_r;
  logic [31:0] fpb_r;
  logic [63:0] total_r;
  logic [15:0] tx_len_r;
  logic [63:0] pkts_r;
  logic [31:0] burst_cnt_r;
  logic [31:0] gap_cnt_r;
  logic        busy_r;
  logic        done_r;

  logic        start_edge_s;
  logic        tx_start_s;
  logic [63:0] pkts_inc_s;
  logic [31:0] burst_inc_s;
  logic        burst_end_s;
  logic        run_done_s;
  logic [31:0] gap_sel_s;

  // Next-frame bookkeeping evaluated for the tx_done cycle, plus the start request.
  always_comb begin
    start_edge_s = enable & ~enable_d_r;
    pkts_inc_s   = pkts_r + 64'd1;
    burst_inc_s  = burst_cnt_r + 32'd1;
    burst_end_s  = (fpb_r != 32'd0) && (burst_inc_s == fpb_r);
    run_done_s   = (total_r != 64'd0) && (pkts_inc_s == total_r);
    if (burst_end_s) begin
      gap_sel_s = ibg_r;
    end else begin
      gap_sel_s = ifg_r;
    end
    // Start is combinational so the emitter sees it in the same cycle tx_ready
    // rises; it is suppressed when enable has dropped since the run aborts.
    if ((state_r == ST_START) && tx.tx_ready && enable) begin
      tx_start_s = 1'b1;
    end else begin
      tx_start_s = 1'b0;
    end
  end

  // Enable edge detector; resets high so an enable held through reset does not start a run.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      enable_d_r <= 1'b1;
    end else begin
      enable_d_r <= enable;
    end
  end

  // Scheduler FSM with its counters, latched config and registered status outputs.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r     <= ST_IDLE;
      ifg_r       <= 32'd0;
      ibg_r       <= 32'd0;
      fpb_r       <= 32'd0;
      total_r     <= 64'd0;
      tx_len_r    <= 16'd0;
      pkts_r      <= 64'd0;
      burst_cnt_r <= 32'd0;
      gap_cnt_r   <= 32'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_edge_s) begin
            ifg_r       <= interframe_gap;
            ibg_r       <= interburst_gap;
            fpb_r       <= frames_per_burst;
            total_r     <= total_frames;
            tx_len_r    <= clamp_len(frame_size);
            pkts_r      <= 64'd0;
            burst_cnt_r <= 32'd0;
            state_r     <= ST_START;
            busy_r      <= 1'b1;
          end else begin
            state_r     <= ST_IDLE;
          end
        end

        ST_START: begin
          if (!enable) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (tx_start_s) begin
            state_r <= ST_WAIT_DONE;
          end else begin
            state_r <= ST_START;
          end
        end

        ST_WAIT_DONE: begin
          // The in-flight frame is always counted, even if enable has dropped.
          if (tx.tx_done) begin
            pkts_r <= pkts_inc_s;
            if (run_done_s) begin
              burst_cnt_r <= burst_inc_s;
              state_r     <= ST_DONE;
              busy_r      <= 1'b0;
              done_r      <= 1'b1;
            end else if (!enable) begin
              burst_cnt_r <= burst_inc_s;
              state_r     <= ST_IDLE;
              busy_r      <= 1'b0;
            end else begin
              if (burst_end_s) begin
                burst_cnt_r <= 32'd0;
              end else begin
                burst_cnt_r <= burst_inc_s;
              end
              if (gap_sel_s == 32'd0) begin
                state_r <= ST_START;
              end else begin
                gap_cnt_r <= gap_sel_s;
                state_r   <= ST_GAP;
              end
            end
          end else begin
            state_r <= ST_WAIT_DONE;
          end
        end

        ST_GAP: begin
          // Counter is loaded with G, so leaving at 1 spends exactly G cycles here.
          if (!enable) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else if (gap_cnt_r <= 32'd1) begin
            gap_cnt_r <= 32'd0;
            state_r   <= ST_START;
          end else begin
            gap_cnt_r <= gap_cnt_r - 32'd1;
            state_r   <= ST_GAP;
          end
        end

        ST_DONE: begin
          if (!enable) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
          end else begin
            state_r <= ST_DONE;
          end
        end

        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign tx.tx_start = tx_start_s;
  assign tx.tx_len   = tx_len_r;
  assign pkts        = pkts_r;
  assign busy        = busy_r;
  assign done        = done_r;

endmodule

// File: tb/tb_traffic_generator_gmii_scheduler.sv
module tb_traffic_generator_gmii_scheduler;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic [31:0] ifg;
  logic [31:0] ibg;
  logic [31:0] fpb;
  logic [63:0] total;
  logic [15:0] fsize;
  logic [63:0] pkts;
  logic        busy;
  logic        done;

  traffic_generator_gmii_scheduler_if tx_if ();

  traffic_generator_gmii_scheduler dut (
    .clk              (clk),
    .resetn           (resetn),
    .enable           (enable),
    .interframe_gap   (ifg),
    .interburst_gap   (ibg),
    .frames_per_burst (fpb),
    .total_frames     (total),
    .frame_size       (fsize),
    .tx               (tx_if),
    .pkts             (pkts),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  int cyc       = 0;
  int start_cnt = 0;
  int n_cmp     = 0;
  int n_err     = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_if.tx_start === 1'b1) start_cnt <= start_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the n-th following falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wait_start(input string tag, output int t);
    t = -1;
    for (int i = 0; i < 300; i++) begin
      if (tx_if.tx_start === 1'b1) begin
        t = cyc;
        break;
      end
      step(1);
    end
    if (t < 0) chk({tag, "_timeout"}, {63'd0, tx_if.tx_start}, 64'd1);
  endtask

  // Emitter model: done pulse d cycles after the start was seen.
  task automatic emit_done(input int d, output int n);
    step(d);
    tx_if.tx_done = 1'b1;
    n = cyc;
    step(1);
    tx_if.tx_done = 1'b0;
  endtask

  int exp_gap2 [5] = '{5, 51, 5, 51, 5};

  initial begin
    int s;
    int n;
    int base;

    resetn         = 1'b0;
    enable         = 1'b0;
    ifg            = 32'd0;
    ibg            = 32'd0;
    fpb            = 32'd0;
    total          = 64'd0;
    fsize          = 16'd0;
    tx_if.tx_ready = 1'b1;
    tx_if.tx_done  = 1'b0;
    step(3);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_pkts", pkts, 64'd0);
    chk("rst_txlen", {48'd0, tx_if.tx_len}, 64'd0);
    chk("rst_txstart", {63'd0, tx_if.tx_start}, 64'd0);
    resetn = 1'b1;
    step(2);

    // 1: three frames, ifg 12, emitter takes 100 cycles
    total = 64'd3; fpb = 32'd0; ifg = 32'd12; ibg = 32'd0; fsize = 16'd10;
    enable = 1'b1;
    step(1);
    chk("t1_busy", {63'd0, busy}, 64'd1);
    chk("t1_txlen_min", {48'd0, tx_if.tx_len}, 64'd60);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      wait_start("t1_start", s);
      if (i > 0) chk("t1_gap", 64'(s - n), 64'd13);
      emit_done(100, n);
    end
    chk("t1_done", {63'd0, done}, 64'd1);
    chk("t1_busy_end", {63'd0, busy}, 64'd0);
    chk("t1_pkts", pkts, 64'd3);
    step(20);
    chk("t1_done_held", {63'd0, done}, 64'd1);
    chk("t1_starts", 64'(start_cnt), 64'd3);
    enable = 1'b0;
    step(1);
    chk("t1_done_clr", {63'd0, done}, 64'd0);
    chk("t1_pkts_kept", pkts, 64'd3);

    // 2: bursts of 2, ifg 4, ibg 50
    total = 64'd6; fpb = 32'd2; ifg = 32'd4; ibg = 32'd50; fsize = 16'd64;
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_start("t2_start", s);
      if (i > 0) chk($sformatf("t2_gap%0d", i), 64'(s - n), 64'(exp_gap2[i-1]));
      emit_done(3, n);
    end
    chk("t2_done", {63'd0, done}, 64'd1);
    chk("t2_pkts", pkts, 64'd6);
    chk("t2_txlen", {48'd0, tx_if.tx_len}, 64'd64);
    enable = 1'b0;
    step(1);

    // 3: endless, ifg 0, enable dropped while frame 7 is in flight
    total = 64'd0; fpb = 32'd0; ifg = 32'd0; ibg = 32'd0;
    base = start_cnt;
    enable = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      wait_start("t3_start", s);
      if (i == 2) chk("t3_gap0", 64'(s - n), 64'd1);
      emit_done(5, n);
    end
    wait_start("t3_start7", s);
    step(2);
    enable = 1'b0;
    step(3);
    chk("t3_busy_wait", {63'd0, busy}, 64'd1);
    tx_if.tx_done = 1'b1;
    step(1);
    tx_if.tx_done = 1'b0;
    chk("t3_pkts", pkts, 64'd7);
    chk("t3_busy", {63'd0, busy}, 64'd0);
    chk("t3_done", {63'd0, done}, 64'd0);
    step(20);
    chk("t3_starts", 64'(start_cnt - base), 64'd7);

    // 4: tx_ready low for 20 cycles in START; oversize frame
    total = 64'd1; fsize = 16'd5000;
    tx_if.tx_ready = 1'b0;
    enable = 1'b1;
    step(1);
    chk("t4_txlen_max", {48'd0, tx_if.tx_len}, 64'd2048);
    base = start_cnt;
    step(20);
    chk("t4_no_start", 64'(start_cnt - base), 64'd0);
    chk("t4_busy", {63'd0, busy}, 64'd1);
    tx_if.tx_ready = 1'b1;
    #1;
    chk("t4_start", {63'd0, tx_if.tx_start}, 64'd1);
    step(1);
    chk("t4_start_low", {63'd0, tx_if.tx_start}, 64'd0);
    chk("t4_one_pulse", 64'(start_cnt - base), 64'd1);
    tx_if.tx_done = 1'b1;
    step(1);
    tx_if.tx_done = 1'b0;
    chk("t4_done", {63'd0, done}, 64'd1);
    chk("t4_pkts", pkts, 64'd1);
    enable = 1'b0;
    step(1);

    // 6a: enable held high across reset release
    resetn = 1'b0;
    enable = 1'b1;
    step(2);
    resetn = 1'b1;
    base = start_cnt;
    step(10);
    chk("t6_no_run_busy", {63'd0, busy}, 64'd0);
    chk("t6_no_run_start", 64'(start_cnt - base), 64'd0);

    // 6b: reset asserted during GAP
    enable = 1'b0;
    step(1);
    total = 64'd0; ifg = 32'd30; fsize = 16'd100;
    enable = 1'b1;
    wait_start("t6_start", s);
    emit_done(3, n);
    step(4);
    chk("t6_gap_busy", {63'd0, busy}, 64'd1);
    chk("t6_gap_pkts", pkts, 64'd1);
    resetn = 1'b0;
    step(1);
    chk("t6_rst_busy", {63'd0, busy}, 64'd0);
    chk("t6_rst_pkts", pkts, 64'd0);
    chk("t6_rst_txlen", {48'd0, tx_if.tx_len}, 64'd0);
    resetn = 1'b1;
    base = start_cnt;
    step(40);
    chk("t6_after_rst_start", 64'(start_cnt - base), 64'd0);
    chk("t6_after_rst_busy", {63'd0, busy}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of run, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
